pc_sequencer: RTL and testbench

Control sequencer for the IPPro program counter. It decides the next instruction-memory address each cycle:
- sequential increment
- taken branch
- zero-overhead hardware loop
- stall on streaming FIFO back-pressure
- halt

It sits between decode/streaming-interface status and instruction-memory fetch, and replaces the free-running increment with a controlled one.

---
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-instruction-address controller with branch, hardware loop, stream stall and halt
module pc_sequencer #(
  parameter int PC_WIDTH        = 10,
  parameter int LOOP_CNT_WIDTH  = 8,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       START,
  input  logic [PC_WIDTH-1:0]        START_ADDR,
  input  logic                       HALT_INSTR,
  input  logic                       BRANCH_TAKEN,
  input  logic [PC_WIDTH-1:0]        BRANCH_TARGET,
  input  logic                       LOOP_SET,
  input  logic [PC_WIDTH-1:0]        LOOP_END,
  input  logic [LOOP_CNT_WIDTH-1:0]  LOOP_COUNT,
  input  logic                       NEED_IN,
  input  logic                       IN_EMPTY,
  input  logic                       NEED_OUT,
  input  logic                       OUT_FULL,
  output logic [PC_WIDTH-1:0]        PC,
  output logic                       FETCH_VALID,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       LOOP_ACTIVE,
  output logic [STALL_CNT_WIDTH-1:0] STALL_CNT
);
  typedef enum logic [1:0] {IDLE, RUN, STALL, HALTED} state_t;
  state_t                    state;
  logic [LOOP_CNT_WIDTH-1:0] loop_cnt;
  logic [PC_WIDTH-1:0]       loop_start;
  logic [PC_WIDTH-1:0]       loop_end;
  logic                      stall;
  logic                      at_end;
  logic [PC_WIDTH-1:0]       pc_inc;
  assign stall  = (NEED_IN & IN_EMPTY) | (NEED_OUT & OUT_FULL);
  assign at_end = LOOP_ACTIVE && (PC == loop_end);
  assign pc_inc = PC + PC_WIDTH'(1);
  // Sequencer: an instruction only advances (and its controls only take effect) when no stream stall is pending
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      PC          <= '0;
      FETCH_VALID <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      LOOP_ACTIVE <= 1'b0;
      loop_cnt    <= '0;
      loop_start  <= '0;
      loop_end    <= '0;
      STALL_CNT   <= '0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            PC          <= START_ADDR;
            STALL_CNT   <= '0;
            LOOP_ACTIVE <= 1'b0;
            FETCH_VALID <= 1'b1;
            BUSY        <= 1'b1;
            state       <= RUN;
          end
        end
        RUN, STALL: begin
          if (stall) begin
            state       <= STALL;
            FETCH_VALID <= 1'b0;
            if (!(&STALL_CNT)) STALL_CNT <= STALL_CNT + STALL_CNT_WIDTH'(1);
          end else if (HALT_INSTR) begin
            state       <= HALTED;
            FETCH_VALID <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b1;
            LOOP_ACTIVE <= 1'b0;
          end else begin
            state       <= RUN;
            FETCH_VALID <= 1'b1;
            if (BRANCH_TAKEN) PC <= BRANCH_TARGET;
            else if (at_end && loop_cnt > LOOP_CNT_WIDTH'(1)) begin
              PC       <= loop_start;
              loop_cnt <= loop_cnt - LOOP_CNT_WIDTH'(1);
            end else begin
              PC <= pc_inc;
              if (at_end) LOOP_ACTIVE <= 1'b0;
            end
            // a new loop setting overrides whatever the current loop did this edge
            if (LOOP_SET) begin
              loop_start  <= pc_inc;
              loop_end    <= LOOP_END;
              loop_cnt    <= (LOOP_COUNT == '0) ? LOOP_CNT_WIDTH'(1) : LOOP_COUNT;
              LOOP_ACTIVE <= 1'b1;
            end
          end
        end
        HALTED: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and randomized checking of pc_sequencer against an instruction-level model
module tb_pc_sequencer;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [9:0]  START_ADDR = '0;
  logic        HALT_INSTR = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [9:0]  BRANCH_TARGET = '0;
  logic        LOOP_SET = 1'b0;
  logic [9:0]  LOOP_END = '0;
  logic [7:0]  LOOP_COUNT = '0;
  logic        NEED_IN = 1'b0;
  logic        IN_EMPTY = 1'b0;
  logic        NEED_OUT = 1'b0;
  logic        OUT_FULL = 1'b0;
  logic [9:0]  PC;
  logic        FETCH_VALID;
  logic        BUSY;
  logic        DONE;
  logic        LOOP_ACTIVE;
  logic [15:0] STALL_CNT;

  pc_sequencer dut (
    .CLK(CLK), .RESET(RESET), .START(START), .START_ADDR(START_ADDR),
    .HALT_INSTR(HALT_INSTR), .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
    .LOOP_SET(LOOP_SET), .LOOP_END(LOOP_END), .LOOP_COUNT(LOOP_COUNT),
    .NEED_IN(NEED_IN), .IN_EMPTY(IN_EMPTY), .NEED_OUT(NEED_OUT), .OUT_FULL(OUT_FULL),
    .PC(PC), .FETCH_VALID(FETCH_VALID), .BUSY(BUSY), .DONE(DONE),
    .LOOP_ACTIVE(LOOP_ACTIVE), .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // model: program execution described as "executing / waiting / just finished"
  int m_pc, m_ls, m_le, m_lc, m_sc;
  bit m_exec, m_fv, m_done, m_la;

  task automatic model_reset();
    m_pc = 0; m_ls = 0; m_le = 0; m_lc = 0; m_sc = 0;
    m_exec = 0; m_fv = 0; m_done = 0; m_la = 0;
  endtask

  task automatic model_step();
    bit blocked;
    int nxt, npc;
    blocked = (NEED_IN && IN_EMPTY) || (NEED_OUT && OUT_FULL);
    if (!RESET) model_reset();
    else if (m_done) m_done = 0;
    else if (!m_exec) begin
      if (START) begin
        m_pc = START_ADDR; m_sc = 0; m_la = 0; m_exec = 1; m_fv = 1;
      end
    end else if (blocked) begin
      m_fv = 0;
      if (m_sc < 65535) m_sc = m_sc + 1;
    end else if (HALT_INSTR) begin
      m_exec = 0; m_fv = 0; m_done = 1; m_la = 0;
    end else begin
      nxt = (m_pc + 1) % 1024;
      npc = nxt;
      if (BRANCH_TAKEN) npc = BRANCH_TARGET;
      else if (m_la && m_pc == m_le) begin
        if (m_lc > 1) begin npc = m_ls; m_lc = m_lc - 1; end
        else m_la = 0;
      end
      if (LOOP_SET) begin
        m_ls = nxt; m_le = LOOP_END; m_lc = (LOOP_COUNT == 0) ? 1 : LOOP_COUNT; m_la = 1;
      end
      m_pc = npc; m_fv = 1;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("pc", PC, m_pc);
    chk("fetch_valid", FETCH_VALID, m_fv);
    chk("busy", BUSY, m_exec);
    chk("done", DONE, m_done);
    chk("loop_active", LOOP_ACTIVE, m_la);
    chk("stall_cnt", STALL_CNT, m_sc);
  endtask

  // one clock: model consumes the inputs driven now, outputs are compared at the following falling edge
  task automatic cyc();
    model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic clear_ctl();
    START = 0; HALT_INSTR = 0; BRANCH_TAKEN = 0; LOOP_SET = 0;
    NEED_IN = 0; IN_EMPTY = 0; NEED_OUT = 0; OUT_FULL = 0;
  endtask

  initial begin
    int exp_seq[7];
    model_reset();
    repeat (2) @(negedge CLK);
    chk("reset_pc", PC, 0);
    chk("reset_busy", BUSY, 0);
    compare_all();
    RESET = 1;
    cyc();

    // sequential run, branch, halt
    START = 1; START_ADDR = 10'h010; cyc(); START = 0;
    chk("start_pc", PC, 'h010);
    chk("start_fv", FETCH_VALID, 1);
    repeat (4) cyc();
    chk("seq_pc", PC, 'h014);
    BRANCH_TAKEN = 1; BRANCH_TARGET = 10'h100; cyc(); BRANCH_TAKEN = 0;
    chk("branch_pc", PC, 'h100);
    cyc();
    HALT_INSTR = 1; cyc(); HALT_INSTR = 0;
    chk("halt_pc", PC, 'h101);
    chk("halt_done", DONE, 1);
    chk("halt_busy", BUSY, 0);
    cyc();
    chk("idle_done", DONE, 0);

    // hardware loop, count 3 then count 0
    START = 1; START_ADDR = 10'h020; cyc(); START = 0;
    LOOP_SET = 1; LOOP_END = 10'h022; LOOP_COUNT = 3; cyc(); LOOP_SET = 0;
    exp_seq = '{'h021, 'h022, 'h021, 'h022, 'h021, 'h022, 'h023};
    chk("loop_seq0", PC, exp_seq[0]);
    for (int i = 1; i < 7; i++) begin
      cyc();
      chk("loop_seq", PC, exp_seq[i]);
    end
    chk("loop_exit_la", LOOP_ACTIVE, 0);
    BRANCH_TAKEN = 1; BRANCH_TARGET = 10'h020; cyc(); BRANCH_TAKEN = 0;
    LOOP_SET = 1; LOOP_COUNT = 0; cyc(); LOOP_SET = 0;
    chk("loop0_la", LOOP_ACTIVE, 1);
    cyc(); cyc();
    chk("loop0_exit", PC, 'h023);

    // input stall with held branch
    BRANCH_TAKEN = 1; BRANCH_TARGET = 10'h030; cyc();
    BRANCH_TARGET = 10'h040; NEED_IN = 1; IN_EMPTY = 1;
    repeat (5) cyc();
    chk("stall_pc", PC, 'h030);
    chk("stall_fv", FETCH_VALID, 0);
    chk("stall_cnt5", STALL_CNT, 5);
    IN_EMPTY = 0; cyc(); clear_ctl();
    chk("release_pc", PC, 'h040);

    // wrap at top of memory, then asynchronous reset mid-loop during a stall
    HALT_INSTR = 1; cyc(); HALT_INSTR = 0; cyc();
    START = 1; START_ADDR = 10'h3FF; cyc(); START = 0;
    cyc();
    chk("wrap_pc", PC, 0);
    LOOP_SET = 1; LOOP_END = 10'h005; LOOP_COUNT = 4; cyc(); LOOP_SET = 0;
    NEED_OUT = 1; OUT_FULL = 1; cyc(); cyc();
    #2 RESET = 0; START = 1;
    #1;
    chk("async_pc", PC, 0);
    chk("async_la", LOOP_ACTIVE, 0);
    chk("async_sc", STALL_CNT, 0);
    chk("async_fv", FETCH_VALID, 0);
    model_reset();
    @(negedge CLK);
    cyc(); cyc();
    chk("reset_hold_busy", BUSY, 0);
    RESET = 1; clear_ctl(); cyc();

    // stall counter saturation and clear on START
    START = 1; START_ADDR = 10'h100; cyc(); START = 0;
    NEED_IN = 1; IN_EMPTY = 1;
    repeat (65539) cyc();
    chk("sat_cnt", STALL_CNT, 'hFFFF);
    clear_ctl(); HALT_INSTR = 1; cyc(); HALT_INSTR = 0; cyc();
    chk("idle_hold_cnt", STALL_CNT, 'hFFFF);
    START = 1; cyc(); START = 0;
    chk("start_clr_cnt", STALL_CNT, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      RESET         = ($urandom % 400) != 0;
      START         = ($urandom % 4) == 0;
      START_ADDR    = 10'($urandom);
      HALT_INSTR    = ($urandom % 30) == 0;
      BRANCH_TAKEN  = ($urandom % 8) == 0;
      BRANCH_TARGET = 10'($urandom);
      LOOP_SET      = ($urandom % 10) == 0;
      LOOP_END      = 10'((m_pc + $urandom_range(0, 5)) % 1024);
      LOOP_COUNT    = 8'($urandom_range(0, 5));
      NEED_IN       = ($urandom % 3) == 0;
      IN_EMPTY      = ($urandom % 2) == 0;
      NEED_OUT      = ($urandom % 4) == 0;
      OUT_FULL      = ($urandom % 2) == 0;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
